// File: rtl/mcs8_pkg.sv
// Shared MCS-8 definitions: T-state codes, machine-cycle length encodings
// and the phase length used by the timing controller.
package mcs8_pkg;

    localparam int PH_LEN = 4;

    localparam logic [2:0] S_WAIT    = 3'b000;
    localparam logic [2:0] S_T2      = 3'b001;
    localparam logic [2:0] S_T1      = 3'b010;
    localparam logic [2:0] S_T1I     = 3'b011;
    localparam logic [2:0] S_T3      = 3'b100;
    localparam logic [2:0] S_T5      = 3'b101;
    localparam logic [2:0] S_STOPPED = 3'b110;
    localparam logic [2:0] S_T4      = 3'b111;

    localparam logic [1:0] CYC_LEN_3  = 2'd0;
    localparam logic [1:0] CYC_LEN_4  = 2'd1;
    localparam logic [1:0] CYC_LEN_5  = 2'd2;
    localparam logic [1:0] CYC_LEN_5B = 2'd3;

    typedef enum logic [2:0] {
        ST_WAIT    = S_WAIT,
        ST_T2      = S_T2,
        ST_T1      = S_T1,
        ST_T1I     = S_T1I,
        ST_T3      = S_T3,
        ST_T5      = S_T5,
        ST_STOPPED = S_STOPPED,
        ST_T4      = S_T4
    } tstate_t;

    // Both length codes 2 and 3 describe a five-state machine cycle.
    function automatic logic has_t5(input logic [1:0] len);
        logic result;
        case (len)
            CYC_LEN_3, CYC_LEN_4: result = 1'b0;
            CYC_LEN_5, CYC_LEN_5B: result = 1'b1;
            default:              result = 1'b0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/mcs8_phase.sv
// Phase generator: a free-running 2-bit counter decoded into the two phase
// strobes, SYNC and the advance strobe that precedes every T-state boundary.
module mcs8_phase
    import mcs8_pkg::*;
(
    input  logic CLK_I,
    input  logic RST_I,
    output logic CLK1_O,
    output logic CLK2_O,
    output logic SYNC_O,
    output logic ADV_O
);

    logic [1:0] phase_cnt;

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            phase_cnt <= 2'd0;
        end else begin
            phase_cnt <= phase_cnt + 2'd1;
        end
    end

    assign CLK1_O = (phase_cnt == 2'd1);
    assign CLK2_O = (phase_cnt == 2'd3);
    assign SYNC_O = ~phase_cnt[1];
    assign ADV_O  = (phase_cnt == 2'(PH_LEN - 1));

endmodule

// File: rtl/mcs8_tstate.sv
// MCS-8 machine-cycle timing controller: sequences the T-states from READY,
// interrupt, halt and cycle-length inputs on every fourth master clock.
module mcs8_tstate
    import mcs8_pkg::*;
(
    input  logic       CLK_I,
    input  logic       RST_I,
    input  logic       READY_I,
    input  logic       INT_I,
    input  logic       HALT_I,
    input  logic [1:0] CYC_LEN_I,
    output logic       CLK1_O,
    output logic       CLK2_O,
    output logic       SYNC_O,
    output logic [2:0] S_O,
    output logic       ADV_O,
    output logic       INTP_O
);

    tstate_t    state;
    tstate_t    state_nxt;
    tstate_t    cycle_start;
    logic [1:0] len_q;
    logic       intp_q;
    logic       adv;

    mcs8_phase u_phase (
        .CLK_I  (CLK_I),
        .RST_I  (RST_I),
        .CLK1_O (CLK1_O),
        .CLK2_O (CLK2_O),
        .SYNC_O (SYNC_O),
        .ADV_O  (adv)
    );

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state <= ST_T1;
        end else if (adv) begin
            state <= state_nxt;
        end
    end

    // Length is captured as T3 is left so T4 can decide on T5 even if the
    // decoder has already moved on.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            len_q <= CYC_LEN_3;
        end else if (adv && state == ST_T3) begin
            len_q <= CYC_LEN_I;
        end
    end

    // Entering T1I acknowledges the interrupt; that clear wins over a
    // simultaneous request, which will re-set the flag one clock later.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            intp_q <= 1'b0;
        end else if (adv && state_nxt == ST_T1I) begin
            intp_q <= 1'b0;
        end else if (INT_I) begin
            intp_q <= 1'b1;
        end
    end

    always_comb begin
        state_nxt   = ST_T1;
        cycle_start = intp_q ? ST_T1I : ST_T1;
        case (state)
            ST_T1, ST_T1I: begin
                state_nxt = ST_T2;
            end
            ST_T2, ST_WAIT: begin
                state_nxt = READY_I ? ST_T3 : ST_WAIT;
            end
            ST_T3: begin
                if (HALT_I) begin
                    state_nxt = ST_STOPPED;
                end else if (CYC_LEN_I == CYC_LEN_3) begin
                    state_nxt = cycle_start;
                end else begin
                    state_nxt = ST_T4;
                end
            end
            ST_T4: begin
                state_nxt = has_t5(len_q) ? ST_T5 : cycle_start;
            end
            ST_T5: begin
                state_nxt = cycle_start;
            end
            ST_STOPPED: begin
                state_nxt = intp_q ? ST_T1I : ST_STOPPED;
            end
            default: begin
                state_nxt = ST_T1;
            end
        endcase
    end

    assign S_O    = state;
    assign ADV_O  = adv;
    assign INTP_O = intp_q;

endmodule
